i2c_target_regif: RTL

- I2C target (slave) front end for the dice design; decodes the shared SDA/SCL pins.
- Translates bus transactions into single-cycle register-file write and read strobes with an auto-incrementing sub-address.
- Sits between the uio[2]/uio[3] pads and the dice configuration/result register bank; the pad layer drives uio_oe[2] from sda_oe, with uio_out[2] tied 0.

---
 rtl/i2c_target_regif.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/i2c_target_regif.sv
// I2C target front end: decodes SCL/SDA into register-file write/read strobes with an auto-incrementing pointer.
// Optional build macro I2C_TARGET_GLITCH_FILTER_EN adds a 3-sample majority filter on the synced pins.
module i2c_target_regif #(
    parameter logic [6:0] I2C_ADDR  = 7'h70,
    parameter int         ADDR_BITS = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 scl_in,
    input  logic                 sda_in,
    output logic                 sda_oe,
    output logic [ADDR_BITS-1:0] reg_addr,
    output logic [7:0]           reg_wdata,
    output logic                 reg_we,
    output logic                 reg_re,
    input  logic [7:0]           reg_rdata,
    output logic                 busy
);
    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
    } state_t;

    localparam logic [ADDR_BITS-1:0] ADDR_ONE = {{(ADDR_BITS-1){1'b0}}, 1'b1};

    logic [1:0]           scl_sync_q, sda_sync_q;
    logic                 scl_h_q, sda_h_q;
    logic                 scl_f, sda_f;
    state_t               state_q;
    logic [2:0]           bitcnt_q;
    logic [7:0]           shift_q;
    logic                 rw_q, ack_q;
    logic                 sda_oe_q, reg_we_q, reg_re_q, busy_q;
    logic [ADDR_BITS-1:0] reg_addr_q;
    logic [7:0]           reg_wdata_q;

    // Synchronizers reset to the idle-bus level so release of reset never fakes an edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_in};
            sda_sync_q <= {sda_sync_q[0], sda_in};
        end
    end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    logic [2:0] scl_win_q, sda_win_q;

    function automatic logic maj3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_win_q <= 3'b111;
            sda_win_q <= 3'b111;
        end else begin
            scl_win_q <= {scl_win_q[1:0], scl_sync_q[1]};
            sda_win_q <= {sda_win_q[1:0], sda_sync_q[1]};
        end
    end

    assign scl_f = maj3(scl_win_q);
    assign sda_f = maj3(sda_win_q);
`else
    assign scl_f = scl_sync_q[1];
    assign sda_f = sda_sync_q[1];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_h_q <= 1'b1;
            sda_h_q <= 1'b1;
        end else begin
            scl_h_q <= scl_f;
            sda_h_q <= sda_f;
        end
    end

    logic       scl_rise, scl_fall, start_det, stop_det, byte_done;
    logic [7:0] rx_byte;

    assign scl_rise  = scl_f & ~scl_h_q;
    assign scl_fall  = ~scl_f & scl_h_q;
    assign start_det = scl_f & scl_h_q & sda_h_q & ~sda_f;
    assign stop_det  = scl_f & scl_h_q & ~sda_h_q & sda_f;
    assign rx_byte   = {shift_q[6:0], sda_f};
    assign byte_done = scl_rise && (bitcnt_q == 3'd7);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            bitcnt_q    <= 3'd0;
            shift_q     <= 8'h00;
            rw_q        <= 1'b0;
            ack_q       <= 1'b0;
            sda_oe_q    <= 1'b0;
            reg_we_q    <= 1'b0;
            reg_re_q    <= 1'b0;
            busy_q      <= 1'b0;
            reg_addr_q  <= '0;
            reg_wdata_q <= 8'h00;
        end else begin
            reg_we_q <= 1'b0;
            reg_re_q <= 1'b0;
            if (reg_we_q)
                reg_addr_q <= reg_addr_q + ADDR_ONE;
            if (start_det) begin
                state_q  <= ADDR;
                bitcnt_q <= 3'd0;
                sda_oe_q <= 1'b0;
                ack_q    <= 1'b0;
            end else if (stop_det) begin
                state_q  <= IDLE;
                busy_q   <= 1'b0;
                sda_oe_q <= 1'b0;
            end else begin
                if (scl_rise && (state_q == ADDR || state_q == SUB || state_q == WDATA)) begin
                    shift_q  <= rx_byte;
                    bitcnt_q <= bitcnt_q + 3'd1;
                end
                case (state_q)
                    ADDR: if (byte_done) begin
                        if (rx_byte[7:1] == I2C_ADDR) begin
                            state_q <= ADDR_ACK;
                            busy_q  <= 1'b1;
                            rw_q    <= rx_byte[0];
                        end else begin
                            state_q <= IGNORE;
                        end
                    end
                    SUB: if (byte_done) begin
                        reg_addr_q <= rx_byte[ADDR_BITS-1:0];
                        state_q    <= SUB_ACK;
                    end
                    WDATA: if (byte_done) begin
                        reg_wdata_q <= rx_byte;
                        reg_we_q    <= 1'b1;
                        state_q     <= WDATA_ACK;
                    end
                    // First fall pulls SDA for the ACK, second fall releases it and moves on
                    ADDR_ACK, SUB_ACK, WDATA_ACK: if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_q <= 1'b1;
                        end else begin
                            sda_oe_q <= 1'b0;
                            bitcnt_q <= 3'd0;
                            if (state_q == ADDR_ACK && rw_q) begin
                                reg_re_q <= 1'b1;
                                shift_q  <= {reg_rdata[6:0], 1'b0};
                                sda_oe_q <= ~reg_rdata[7];
                                state_q  <= RDATA;
                            end else if (state_q == ADDR_ACK) begin
                                state_q <= SUB;
                            end else begin
                                state_q <= WDATA;
                            end
                        end
                    end
                    RDATA: begin
                        if (scl_rise) begin
                            bitcnt_q <= bitcnt_q + 3'd1;
                            if (bitcnt_q == 3'd7) begin
                                state_q <= RDATA_ACK;
                                ack_q   <= 1'b0;
                            end
                        end else if (scl_fall) begin
                            sda_oe_q <= ~shift_q[7];
                            shift_q  <= {shift_q[6:0], 1'b0};
                        end
                    end
                    // Pointer advances on the ACK rise so reg_rdata is settled by the following fall
                    RDATA_ACK: begin
                        if (scl_rise) begin
                            if (sda_f) begin
                                state_q <= IGNORE;
                            end else begin
                                ack_q      <= 1'b1;
                                reg_addr_q <= reg_addr_q + ADDR_ONE;
                            end
                        end else if (scl_fall) begin
                            if (ack_q) begin
                                reg_re_q <= 1'b1;
                                shift_q  <= {reg_rdata[6:0], 1'b0};
                                sda_oe_q <= ~reg_rdata[7];
                                bitcnt_q <= 3'd0;
                                state_q  <= RDATA;
                            end else begin
                                sda_oe_q <= 1'b0;
                            end
                        end
                    end
                    default: sda_oe_q <= 1'b0;
                endcase
            end
        end
    end

    assign sda_oe    = sda_oe_q;
    assign reg_addr  = reg_addr_q;
    assign reg_wdata = reg_wdata_q;
    assign reg_we    = reg_we_q;
    assign reg_re    = reg_re_q;
    assign busy      = busy_q;
endmodule
